// File: rtl/fpu_fetch_sequencer.sv
// fpu_fetch_sequencer: fetches instructions from the program SRAM and issues them one slot at a time to the FPU path.
module fpu_fetch_sequencer #(
  parameter int ADDR_W = 8,
  parameter int INST_W = 32,
  parameter logic [INST_W-1:0] END_INST = 32'h0000_0073,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              prog_done_i,
  output logic              mem_en_o,
  output logic [ADDR_W+1:0] pc_o,
  input  logic [INST_W-1:0] mem_rdata_i,
  output logic [INST_W-1:0] inst_o,
  output logic              inst_valid_o,
  input  logic              stall_i,
  input  logic              complete_i,
  input  logic              step_mode_i,
  input  logic              step_i,
  input  logic              halt_req_i,
  output logic              busy_o,
  output logic              halt_o,
  output logic              end_o,
  output logic [CNT_W-1:0]  inst_count_o
);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_CAPTURE, S_ISSUE, S_EXEC, S_STEP_WAIT, S_HALT} state_t;
  state_t r_state, w_next;
  logic [ADDR_W-1:0] r_pc;
  logic [INST_W-1:0] r_inst;
  logic [CNT_W-1:0] r_cnt;
  logic r_end;
  logic w_adv, w_pc_inc, w_pc_clr, w_set_end, w_clr_end;
  assign pc_o = {r_pc, 2'b00};
  assign inst_o = r_inst;
  assign end_o = r_end;
  assign inst_count_o = r_cnt;
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    w_adv = 1'b0;
    w_pc_inc = 1'b0;
    w_pc_clr = 1'b0;
    w_set_end = 1'b0;
    w_clr_end = 1'b0;
    mem_en_o = 1'b0;
    inst_valid_o = 1'b0;
    halt_o = 1'b0;
    busy_o = (r_state != S_IDLE) && (r_state != S_HALT);
    case (r_state)
      S_IDLE: w_next = prog_done_i ? S_FETCH : S_IDLE;
      S_FETCH: begin
        mem_en_o = !halt_req_i;
        w_next = halt_req_i ? S_HALT : S_CAPTURE;
      end
      S_CAPTURE: begin
        w_set_end = (mem_rdata_i == END_INST);
        w_next = w_set_end ? S_HALT : S_ISSUE;
      end
      S_ISSUE: begin
        inst_valid_o = 1'b1;
        w_next = stall_i ? S_EXEC : S_ISSUE;
        w_adv = !stall_i;
      end
      S_EXEC: w_adv = complete_i;
      S_STEP_WAIT: w_next = halt_req_i ? S_HALT : (step_i || !step_mode_i) ? S_FETCH : S_STEP_WAIT;
      S_HALT: begin
        halt_o = 1'b1;
        w_clr_end = !prog_done_i;
        w_next = prog_done_i ? S_HALT : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // Running off the last word ends the program rather than wrapping to 0.
    if (w_adv) begin
      w_set_end = &r_pc;
      w_pc_inc = !(&r_pc);
      w_next = (&r_pc || halt_req_i) ? S_HALT : step_mode_i ? S_STEP_WAIT : S_FETCH;
    end
    if (!prog_done_i && busy_o) begin
      w_next = S_IDLE;
      w_pc_clr = 1'b1;
      w_set_end = 1'b0;
    end
    // pc reads as 0 for the whole time HALT is visible.
    w_pc_clr = w_pc_clr || (w_next == S_HALT) || (r_state == S_HALT);
  end
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_pc <= '0;
      r_inst <= '0;
      r_cnt <= '0;
      r_end <= 1'b0;
    end else begin
      r_pc <= w_pc_clr ? '0 : w_pc_inc ? r_pc + ADDR_W'(1) : r_pc;
      if (r_state == S_CAPTURE) r_inst <= mem_rdata_i;
      if (r_state == S_ISSUE && r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
      r_end <= w_set_end || (r_end && !w_clr_end);
    end
  end
endmodule
